// File: rtl/uart_word_sequencer.sv
// ---------------------------------------------------------------------------
// uart_word_sequencer
//
// Moves one 16-bit word across the UART link as two bytes, high byte first.
// A single start/busy handshake replaces hand-sequenced enable/write pulsing:
// the block drives the transmitter, enables and watches the receiver, and
// reassembles the looped-back word, reporting a match or an error code.
//
// Optional feature macro: SEQ_RETRY_EN
//   undefined : any receive error goes straight to the error state
//   defined   : frame/parity errors retransmit the same byte up to MAX_RETRY
//               times before giving up (timeouts never retry)
//
// Parameters:
//   TIMEOUT_CYCLES  clk cycles allowed in a wait before a timeout (16-bit)
//   MAX_RETRY       per-byte retransmissions (only with SEQ_RETRY_EN)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-low reset
//   start       in   request to send word_in, honoured only when idle
//   word_in     in   16-bit word, latched on the accepted start
//   Tx_Data     out  byte presented to the transmitter
//   Tx_WR       out  one-cycle transmitter write strobe
//   Tx_EN       out  transmitter enable
//   Tx_BUSY     in   transmitter busy
//   Rx_EN       out  receiver enable
//   Rx_DATA     in   received byte
//   Rx_VALID    in   received byte valid
//   Rx_FERROR   in   receiver frame error
//   Rx_PERROR   in   receiver parity error
//   busy        out  transfer in progress
//   word_out    out  reassembled word
//   word_valid  out  one-cycle pulse when word_out updates
//   match       out  word_out equals the latched word
//   err         out  one-cycle error pulse
//   err_code    out  01 frame, 10 parity, 11 timeout; held until next start
// ---------------------------------------------------------------------------
module uart_word_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 20000
`ifdef SEQ_RETRY_EN
    ,
    parameter int unsigned MAX_RETRY = 2
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] word_in,
    output logic [7:0]  Tx_Data,
    output logic        Tx_WR,
    output logic        Tx_EN,
    input  logic        Tx_BUSY,
    output logic        Rx_EN,
    input  logic [7:0]  Rx_DATA,
    input  logic        Rx_VALID,
    input  logic        Rx_FERROR,
    input  logic        Rx_PERROR,
    output logic        busy,
    output logic [15:0] word_out,
    output logic        word_valid,
    output logic        match,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEND_HI = 3'd1;
    localparam logic [2:0] S_WAIT_HI = 3'd2;
    localparam logic [2:0] S_GAP     = 3'd3;
    localparam logic [2:0] S_SEND_LO = 3'd4;
    localparam logic [2:0] S_WAIT_LO = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_ERR     = 3'd7;

    // The counter starts at 0 on state entry, so the last allowed value is
    // one less than the budget.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

`ifdef SEQ_RETRY_EN
    localparam int unsigned   RW          = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    logic [RW-1:0] retryCnt_q, retryCnt_d;
    logic          gapToHi_q, gapToHi_d;
`endif

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] word_q, word_d;
    logic [7:0]  hiByte_q, hiByte_d;
    logic [7:0]  txData_q, txData_d;
    logic        txWr_q, txWr_d;
    logic        enable_q, enable_d;
    logic        busy_q, busy_d;
    logic [15:0] wordOut_q, wordOut_d;
    logic        wordValid_q, wordValid_d;
    logic        match_q, match_d;
    logic        err_q, err_d;
    logic [1:0]  errCode_q, errCode_d;

    logic        timeoutHit;
    logic        rxErr;
    logic [1:0]  rxErrCode;

    assign timeoutHit = (cnt_q == TIMEOUT_LAST);
    assign rxErr      = Rx_FERROR | Rx_PERROR;
    // Frame error outranks parity when both flags arrive together.
    assign rxErrCode  = Rx_FERROR ? 2'b01 : 2'b10;

    // Next-state logic. Every output register is computed here from the
    // upcoming state so the outputs line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        hiByte_d    = hiByte_q;
        txData_d    = txData_q;
        txWr_d      = 1'b0;
        busy_d      = busy_q;
        wordOut_d   = wordOut_q;
        wordValid_d = 1'b0;
        match_d     = match_q;
        err_d       = 1'b0;
        errCode_d   = errCode_q;
`ifdef SEQ_RETRY_EN
        retryCnt_d  = retryCnt_q;
        gapToHi_d   = gapToHi_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    word_d    = word_in;
                    txData_d  = word_in[15:8];
                    errCode_d = 2'b00;
                    busy_d    = 1'b1;
                    state_d   = S_SEND_HI;
`ifdef SEQ_RETRY_EN
                    retryCnt_d = '0;
`endif
                end
            end

            // The write strobe takes one cycle inside SEND; once it has been
            // issued the transmitter's busy flag is no longer of interest.
            S_SEND_HI, S_SEND_LO: begin
                if (txWr_q) begin
                    state_d = (state_q == S_SEND_HI) ? S_WAIT_HI : S_WAIT_LO;
                end else if (Tx_BUSY) begin
                    if (timeoutHit) begin
                        state_d   = S_ERR;
                        err_d     = 1'b1;
                        errCode_d = 2'b11;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    txWr_d = 1'b1;
                end
            end

            // Priority: receive error, then valid byte, then timeout.
            S_WAIT_HI, S_WAIT_LO: begin
                if (rxErr) begin
`ifdef SEQ_RETRY_EN
                    if (retryCnt_q < RETRY_LIMIT) begin
                        retryCnt_d = retryCnt_q + 1'b1;
                        gapToHi_d  = (state_q == S_WAIT_HI);
                        state_d    = S_GAP;
                    end else begin
                        state_d   = S_ERR;
                        err_d     = 1'b1;
                        errCode_d = rxErrCode;
                    end
`else
                    state_d   = S_ERR;
                    err_d     = 1'b1;
                    errCode_d = rxErrCode;
`endif
                end else if (Rx_VALID) begin
`ifdef SEQ_RETRY_EN
                    retryCnt_d = '0;
                    gapToHi_d  = 1'b0;
`endif
                    if (state_q == S_WAIT_HI) begin
                        hiByte_d = Rx_DATA;
                        state_d  = S_GAP;
                    end else begin
                        wordOut_d   = {hiByte_q, Rx_DATA};
                        wordValid_d = 1'b1;
                        match_d     = ({hiByte_q, Rx_DATA} == word_q);
                        state_d     = S_DONE;
                    end
                end else if (timeoutHit) begin
                    state_d   = S_ERR;
                    err_d     = 1'b1;
                    errCode_d = 2'b11;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_GAP: begin
`ifdef SEQ_RETRY_EN
                if (gapToHi_q) begin
                    txData_d = word_q[15:8];
                    state_d  = S_SEND_HI;
                end else begin
                    txData_d = word_q[7:0];
                    state_d  = S_SEND_LO;
                end
`else
                txData_d = word_q[7:0];
                state_d  = S_SEND_LO;
`endif
            end

            S_DONE, S_ERR: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Transmitter and receiver are enabled only while a byte is in play.
        enable_d = (state_d == S_SEND_HI) || (state_d == S_WAIT_HI) ||
                   (state_d == S_SEND_LO) || (state_d == S_WAIT_LO);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            hiByte_q    <= '0;
            txData_q    <= '0;
            txWr_q      <= 1'b0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            wordOut_q   <= '0;
            wordValid_q <= 1'b0;
            match_q     <= 1'b0;
            err_q       <= 1'b0;
            errCode_q   <= 2'b00;
`ifdef SEQ_RETRY_EN
            retryCnt_q  <= '0;
            gapToHi_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            hiByte_q    <= hiByte_d;
            txData_q    <= txData_d;
            txWr_q      <= txWr_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            wordOut_q   <= wordOut_d;
            wordValid_q <= wordValid_d;
            match_q     <= match_d;
            err_q       <= err_d;
            errCode_q   <= errCode_d;
`ifdef SEQ_RETRY_EN
            retryCnt_q  <= retryCnt_d;
            gapToHi_q   <= gapToHi_d;
`endif
        end
    end

    assign Tx_Data    = txData_q;
    assign Tx_WR      = txWr_q;
    assign Tx_EN      = enable_q;
    assign Rx_EN      = enable_q;
    assign busy       = busy_q;
    assign word_out   = wordOut_q;
    assign word_valid = wordValid_q;
    assign match      = match_q;
    assign err        = err_q;
    assign err_code   = errCode_q;

endmodule

// File: tb/tb_uart_word_sequencer.sv
// ---------------------------------------------------------------------------
// tb_uart_word_sequencer
//
// Directed bench for uart_word_sequencer. The bench plays the role of the
// transmitter/receiver pair by driving Tx_BUSY and the Rx_* status lines.
// A short timeout budget keeps the timeout scenarios quick.
// ---------------------------------------------------------------------------
module tb_uart_word_sequencer;

    localparam int unsigned TO = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] word_in = '0;
    logic [7:0]  Tx_Data;
    logic        Tx_WR;
    logic        Tx_EN;
    logic        Tx_BUSY = 1'b0;
    logic        Rx_EN;
    logic [7:0]  Rx_DATA = '0;
    logic        Rx_VALID = 1'b0;
    logic        Rx_FERROR = 1'b0;
    logic        Rx_PERROR = 1'b0;
    logic        busy;
    logic [15:0] word_out;
    logic        word_valid;
    logic        match;
    logic        err;
    logic [1:0]  err_code;

    int total = 0;
    int bad = 0;

    uart_word_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_in    (word_in),
        .Tx_Data    (Tx_Data),
        .Tx_WR      (Tx_WR),
        .Tx_EN      (Tx_EN),
        .Tx_BUSY    (Tx_BUSY),
        .Rx_EN      (Rx_EN),
        .Rx_DATA    (Rx_DATA),
        .Rx_VALID   (Rx_VALID),
        .Rx_FERROR  (Rx_FERROR),
        .Rx_PERROR  (Rx_PERROR),
        .busy       (busy),
        .word_out   (word_out),
        .word_valid (word_valid),
        .match      (match),
        .err        (err),
        .err_code   (err_code)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a complete clean transfer from IDLE, ending just after the DONE edge.
    task automatic runTransfer(input logic [15:0] w, input logic [7:0] hiRx, input logic [7:0] loRx);
        start = 1'b1; word_in = w; step();
        start = 1'b0; step();
        step();
        Rx_VALID = 1'b1; Rx_DATA = hiRx; step();
        Rx_VALID = 1'b0; step();
        step();
        step();
        Rx_VALID = 1'b1; Rx_DATA = loRx; step();
        Rx_VALID = 1'b0;
    endtask

    // Reset values on every output.
    task automatic test_reset();
        reset = 1'b0;
        step(); step();
        total++;
        if ({Tx_Data, Tx_WR, Tx_EN, Rx_EN, busy, word_out, word_valid, match, err, err_code} !== 33'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got %h want 0",
                     {Tx_Data, Tx_WR, Tx_EN, Rx_EN, busy, word_out, word_valid, match, err, err_code});
        end
        reset = 1'b1;
        step();
        total++;
        if (Tx_EN !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_after_reset Tx_EN=%b busy=%b want 0 0", Tx_EN, busy);
        end
    endtask

    // Cycle-exact clean transfer of 16'hA194.
    task automatic test_loopback();
        start = 1'b1; word_in = 16'hA194; step();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || Tx_EN !== 1'b1 || Rx_EN !== 1'b1 || Tx_Data !== 8'hA1 || Tx_WR !== 1'b0) begin
            bad++;
            $display("[TB] FAIL send_hi busy=%b en=%b%b data=%h wr=%b want 1 11 a1 0", busy, Tx_EN, Rx_EN, Tx_Data, Tx_WR);
        end
        step();
        total++;
        if (Tx_WR !== 1'b1 || Tx_Data !== 8'hA1) begin
            bad++;
            $display("[TB] FAIL wr_hi wr=%b data=%h want 1 a1", Tx_WR, Tx_Data);
        end
        step();
        total++;
        if (Tx_WR !== 1'b0 || Tx_EN !== 1'b1 || Tx_Data !== 8'hA1) begin
            bad++;
            $display("[TB] FAIL wait_hi wr=%b en=%b data=%h want 0 1 a1", Tx_WR, Tx_EN, Tx_Data);
        end
        Rx_VALID = 1'b1; Rx_DATA = 8'hA1; step();
        Rx_VALID = 1'b0;
        total++;
        if (Tx_EN !== 1'b0 || Rx_EN !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL gap en=%b%b busy=%b want 00 1", Tx_EN, Rx_EN, busy);
        end
        step();
        total++;
        if (Tx_EN !== 1'b1 || Tx_Data !== 8'h94 || Tx_WR !== 1'b0) begin
            bad++;
            $display("[TB] FAIL send_lo en=%b data=%h wr=%b want 1 94 0", Tx_EN, Tx_Data, Tx_WR);
        end
        step();
        total++;
        if (Tx_WR !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wr_lo wr=%b want 1", Tx_WR);
        end
        step();
        Rx_VALID = 1'b1; Rx_DATA = 8'h94; step();
        Rx_VALID = 1'b0;
        total++;
        if (word_valid !== 1'b1 || word_out !== 16'hA194 || match !== 1'b1 || err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL done valid=%b word=%h match=%b err=%b busy=%b want 1 a194 1 0 1",
                     word_valid, word_out, match, err, busy);
        end
        step();
        total++;
        if (word_valid !== 1'b0 || busy !== 1'b0 || Tx_EN !== 1'b0) begin
            bad++;
            $display("[TB] FAIL after_done valid=%b busy=%b en=%b want 0 0 0", word_valid, busy, Tx_EN);
        end
    endtask

    // Corrupted low byte: word_out follows the received bytes, match drops.
    task automatic test_mismatch();
        runTransfer(16'hBEEF, 8'hBE, 8'hEE);
        total++;
        if (word_valid !== 1'b1 || word_out !== 16'hBEEE || match !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mismatch valid=%b word=%h match=%b want 1 beee 0", word_valid, word_out, match);
        end
        step();
    endtask

    // Write strobe held off while the transmitter is busy; Rx_VALID outside WAIT ignored.
    task automatic test_busy_hold();
        int wrSeen;
        wrSeen = 0;
        Tx_BUSY = 1'b1;
        start = 1'b1; word_in = 16'h0F0F; step();
        start = 1'b0;
        Rx_VALID = 1'b1; Rx_DATA = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            if (Tx_WR) wrSeen++;
        end
        Rx_VALID = 1'b0;
        total++;
        if (wrSeen != 0) begin
            bad++;
            $display("[TB] FAIL wr_while_busy count=%0d want 0", wrSeen);
        end
        Tx_BUSY = 1'b0; step();
        total++;
        if (Tx_WR !== 1'b1 || Tx_Data !== 8'h0F) begin
            bad++;
            $display("[TB] FAIL wr_after_busy wr=%b data=%h want 1 0f", Tx_WR, Tx_Data);
        end
        step();
        Rx_VALID = 1'b1; Rx_DATA = 8'h0F; step();
        Rx_VALID = 1'b0; step();
        step();
        step();
        Rx_VALID = 1'b1; Rx_DATA = 8'h0F; step();
        Rx_VALID = 1'b0;
        total++;
        if (word_valid !== 1'b1 || word_out !== 16'h0F0F || match !== 1'b1) begin
            bad++;
            $display("[TB] FAIL busy_hold_word valid=%b word=%h match=%b want 1 0f0f 1", word_valid, word_out, match);
        end
        step();
    endtask

    // Both error flags with Rx_VALID in WAIT_LO: frame code wins, word_out untouched.
    task automatic test_frame_priority();
        start = 1'b1; word_in = 16'h1234; step();
        start = 1'b0; step();
        step();
        Rx_VALID = 1'b1; Rx_DATA = 8'h12; step();
        Rx_VALID = 1'b0; step();
        step();
        step();
        Rx_VALID = 1'b1; Rx_FERROR = 1'b1; Rx_PERROR = 1'b1; Rx_DATA = 8'h34; step();
        Rx_VALID = 1'b0; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0;
        total++;
        if (err !== 1'b1 || err_code !== 2'b01 || word_valid !== 1'b0 || busy !== 1'b1 || word_out !== 16'h0F0F) begin
            bad++;
            $display("[TB] FAIL frame_err err=%b code=%b valid=%b busy=%b word=%h want 1 01 0 1 0f0f",
                     err, err_code, word_valid, busy, word_out);
        end
        step();
        total++;
        if (busy !== 1'b0 || err !== 1'b0 || err_code !== 2'b01) begin
            bad++;
            $display("[TB] FAIL frame_after busy=%b err=%b code=%b want 0 0 01", busy, err, err_code);
        end
    endtask

    // Parity error on the high byte.
    task automatic test_parity();
        start = 1'b1; word_in = 16'h5555; step();
        start = 1'b0;
        total++;
        if (err_code !== 2'b00) begin
            bad++;
            $display("[TB] FAIL code_clear_on_start code=%b want 00", err_code);
        end
        step();
        step();
        Rx_PERROR = 1'b1; step();
        Rx_PERROR = 1'b0;
        total++;
        if (err !== 1'b1 || err_code !== 2'b10 || Tx_EN !== 1'b0) begin
            bad++;
            $display("[TB] FAIL parity_err err=%b code=%b en=%b want 1 10 0", err, err_code, Tx_EN);
        end
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL parity_busy busy=%b want 0", busy);
        end
    endtask

    // Retry build: one parity error on the low byte forces one resend of 8'h94.
    task automatic test_retry();
        start = 1'b1; word_in = 16'hA194; step();
        start = 1'b0; step();
        step();
        Rx_VALID = 1'b1; Rx_DATA = 8'hA1; step();
        Rx_VALID = 1'b0; step();
        step();
        step();
        Rx_PERROR = 1'b1; step();
        Rx_PERROR = 1'b0;
        total++;
        if (err !== 1'b0 || Tx_EN !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL retry_gap err=%b en=%b busy=%b want 0 0 1", err, Tx_EN, busy);
        end
        step();
        step();
        total++;
        if (Tx_WR !== 1'b1 || Tx_Data !== 8'h94) begin
            bad++;
            $display("[TB] FAIL retry_resend wr=%b data=%h want 1 94", Tx_WR, Tx_Data);
        end
        step();
        Rx_VALID = 1'b1; Rx_DATA = 8'h94; step();
        Rx_VALID = 1'b0;
        total++;
        if (word_valid !== 1'b1 || word_out !== 16'hA194 || err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL retry_done valid=%b word=%h err=%b want 1 a194 0", word_valid, word_out, err);
        end
        step();
    endtask

    // No Rx_VALID: timeout fires exactly TO cycles after entering WAIT_HI.
    task automatic test_timeout();
        int early;
        early = 0;
        start = 1'b1; word_in = 16'h7777; step();
        start = 1'b0; step();
        step();
        for (int i = 0; i < TO - 1; i++) begin
            step();
            if (err) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("[TB] FAIL timeout_early pulses=%0d want 0", early);
        end
        step();
        total++;
        if (err !== 1'b1 || err_code !== 2'b11 || Tx_EN !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout err=%b code=%b en=%b want 1 11 0", err, err_code, Tx_EN);
        end
        step();
        total++;
        if (busy !== 1'b0 || err_code !== 2'b11) begin
            bad++;
            $display("[TB] FAIL timeout_after busy=%b code=%b want 0 11", busy, err_code);
        end
    endtask

    // Rx_VALID on the very cycle the timeout would expire wins.
    task automatic test_valid_vs_timeout();
        start = 1'b1; word_in = 16'h6789; step();
        start = 1'b0; step();
        step();
        for (int i = 0; i < TO - 1; i++) step();
        Rx_VALID = 1'b1; Rx_DATA = 8'h67; step();
        Rx_VALID = 1'b0;
        total++;
        if (err !== 1'b0 || Tx_EN !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL valid_vs_timeout err=%b en=%b busy=%b want 0 0 1", err, Tx_EN, busy);
        end
        step();
        step();
        step();
        Rx_VALID = 1'b1; Rx_DATA = 8'h89; step();
        Rx_VALID = 1'b0;
        total++;
        if (word_valid !== 1'b1 || word_out !== 16'h6789 || match !== 1'b1) begin
            bad++;
            $display("[TB] FAIL valid_vs_timeout_word valid=%b word=%h match=%b want 1 6789 1", word_valid, word_out, match);
        end
        step();
    endtask

    // One-edge reset during WAIT_LO, then a clean transfer of 16'h1234.
    task automatic test_reset_mid();
        start = 1'b1; word_in = 16'h4321; step();
        start = 1'b0; step();
        step();
        Rx_VALID = 1'b1; Rx_DATA = 8'h43; step();
        Rx_VALID = 1'b0; step();
        step();
        step();
        reset = 1'b0; start = 1'b1; word_in = 16'h1234; step();
        total++;
        if ({Tx_Data, Tx_WR, Tx_EN, Rx_EN, busy, word_out, word_valid, match, err, err_code} !== 33'd0) begin
            bad++;
            $display("[TB] FAIL reset_mid got %h want 0",
                     {Tx_Data, Tx_WR, Tx_EN, Rx_EN, busy, word_out, word_valid, match, err, err_code});
        end
        reset = 1'b1; start = 1'b0;
        step();
        runTransfer(16'h1234, 8'h12, 8'h34);
        total++;
        if (word_valid !== 1'b1 || word_out !== 16'h1234 || match !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_mid_word valid=%b word=%h match=%b want 1 1234 1", word_valid, word_out, match);
        end
        step();
    endtask

    // start held high: one transfer per IDLE visit, the next only after DONE.
    task automatic test_back_to_back();
        logic pend;
        int   wrCnt;
        int   wvCnt;
        int   busyGap;
        logic busyAt8;
        int   wv2;
        int   wr2;
        pend = 1'b0; wrCnt = 0; wvCnt = 0; busyGap = 0; busyAt8 = 1'b1; wv2 = 0; wr2 = 0;
        start = 1'b1; word_in = 16'h5A5A;
        for (int k = 0; k < 9; k++) begin
            step();
            Rx_VALID = pend; Rx_DATA = Tx_Data;
            pend = Tx_WR;
            if (Tx_WR) wrCnt++;
            if (word_valid) wvCnt++;
            if (k == 8) busyAt8 = busy;
            else if (!busy) busyGap++;
        end
        total++;
        if (wrCnt != 2 || wvCnt != 1) begin
            bad++;
            $display("[TB] FAIL held_first wr=%0d valid=%0d want 2 1", wrCnt, wvCnt);
        end
        total++;
        if (busyAt8 !== 1'b0 || busyGap != 0) begin
            bad++;
            $display("[TB] FAIL held_busy idle_busy=%b gaps=%0d want 0 0", busyAt8, busyGap);
        end
        step();
        Rx_VALID = 1'b0;
        total++;
        if (busy !== 1'b1 || Tx_Data !== 8'h5A) begin
            bad++;
            $display("[TB] FAIL held_second_start busy=%b data=%h want 1 5a", busy, Tx_Data);
        end
        start = 1'b0;
        pend = 1'b0;
        for (int k = 0; k < 20 && wv2 == 0; k++) begin
            step();
            Rx_VALID = pend; Rx_DATA = Tx_Data;
            pend = Tx_WR;
            if (Tx_WR) wr2++;
            if (word_valid) wv2++;
        end
        Rx_VALID = 1'b0;
        total++;
        if (wv2 != 1 || wr2 != 2 || word_out !== 16'h5A5A) begin
            bad++;
            $display("[TB] FAIL held_second valid=%0d wr=%0d word=%h want 1 2 5a5a", wv2, wr2, word_out);
        end
        step();
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL held_end busy=%b want 0", busy);
        end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_loopback();
        test_mismatch();
        test_busy_hold();
`ifdef SEQ_RETRY_EN
        test_retry();
`else
        test_frame_priority();
        test_parity();
`endif
        test_timeout();
        test_valid_vs_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
